// File: rtl/seg_ascii_pkg.sv
// Shared definitions for the ASCII-to-7-segment display path.
//   - Segment codes in active-high form, bit order {dp,g,f,e,d,c,b,a}
//   - ASCII control characters recognised by the entry logic
//   - Entry/commit state encoding
//   - hex_seg(): nibble to segment code lookup
package seg_ascii_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int         SEG_DP_BIT = 7;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DOT = 8'h2E;

    typedef enum logic {
        ENTRY  = 1'b0,
        COMMIT = 1'b1
    } state_t;

    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_seg = SEG_0;
            4'h1:    hex_seg = SEG_1;
            4'h2:    hex_seg = SEG_2;
            4'h3:    hex_seg = SEG_3;
            4'h4:    hex_seg = SEG_4;
            4'h5:    hex_seg = SEG_5;
            4'h6:    hex_seg = SEG_6;
            4'h7:    hex_seg = SEG_7;
            4'h8:    hex_seg = SEG_8;
            4'h9:    hex_seg = SEG_9;
            4'hA:    hex_seg = SEG_A;
            4'hB:    hex_seg = SEG_B;
            4'hC:    hex_seg = SEG_C;
            4'hD:    hex_seg = SEG_D;
            4'hE:    hex_seg = SEG_E;
            default: hex_seg = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_ascii_display_decode.sv
// Combinational ASCII decoder for characters that occupy a digit position.
//   char_in : ASCII character
//   valid   : 1 when char_in is 0-9, A-F, a-f, '-' or ' '
//   code    : active-high segment code (blank when not valid)
// Control characters (CR, LF, BS, '.') are deliberately not valid here; the
// entry logic handles them itself.
module seg_ascii_decode
    import seg_ascii_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       valid,
    output logic [7:0] code
);

    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path
        // leaves it unassigned, which would otherwise infer a latch.
        valid = 1'b0;
        code  = SEG_BLANK;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            valid = 1'b1;
            code  = hex_seg(char_in[3:0]);
        end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                     (char_in >= 8'h61 && char_in <= 8'h66)) begin
            // Low nibble of 'A'/'a' is 1, so +9 maps it onto 0xA.
            valid = 1'b1;
            code  = hex_seg(char_in[3:0] + 4'd9);
        end else if (char_in == 8'h2D) begin
            valid = 1'b1;
            code  = SEG_MINUS;
        end else if (char_in == 8'h20) begin
            valid = 1'b1;
            code  = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_ascii_display.sv
// ASCII character stream to multi-digit 7-segment display.
//   CLK, RST      : clock, synchronous active-high reset
//   char_in/valid : ASCII character stream, accepted when char_ready is high
//   char_ready    : low only during the single commit cycle
//   blank_en      : forces all segments off
//   blink_en      : blinks the displayed value at BLINK_DIV half-period
//   seg_out       : digit k at [8k+7:8k], {dp,g,f,e,d,c,b,a}, digit 0 rightmost
//   commit_pulse  : one cycle when the display register takes the staged value
//   bad_char      : one cycle when an unsupported character was accepted
//   overflow      : sticky, a digit was shifted out since the last commit
//   char_count    : characters staged since the last commit, saturating
// Characters build up in a staging buffer; a CR/LF copies it to the display
// register in one step so a half-typed value never reaches the segments.
module seg_ascii_display
    import seg_ascii_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [7:0]              char_in,
    input  logic                    char_valid,
    output logic                    char_ready,
    input  logic                    blank_en,
    input  logic                    blink_en,
    output logic [8*NUM_DIGITS-1:0] seg_out,
    output logic                    commit_pulse,
    output logic                    bad_char,
    output logic                    overflow,
    output logic [3:0]              char_count
);

    localparam int                 SEG_W      = 8 * NUM_DIGITS;
    localparam int                 BLINK_W    = $clog2(BLINK_DIV);
    localparam logic [3:0]         FULL_COUNT = 4'(NUM_DIGITS);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SEG_W-1:0]   POL_MASK   = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

    state_t               state_q, state_d;
    logic                 xfer, is_term;
    logic                 dec_valid;
    logic [7:0]           dec_code;
    logic [7:0]           stage_q [NUM_DIGITS];
    logic [SEG_W-1:0]     disp_q;
    logic [SEG_W-1:0]     seg_q;
    logic [3:0]           count_q;
    logic                 ovf_q, commit_q, bad_q;
    logic [BLINK_W-1:0]   blink_cnt_q;
    logic                 blink_phase_q;

    seg_ascii_decode u_decode (
        .char_in (char_in),
        .valid   (dec_valid),
        .code    (dec_code)
    );

    assign xfer    = char_valid && char_ready;
    assign is_term = (char_in == CR) || (char_in == LF);

    // ---------------- state machine ----------------
    always_ff @(posedge CLK) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // the pre-edge values, independent of block ordering.
        if (RST) state_q <= ENTRY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        char_ready = 1'b0;
        case (state_q)
            ENTRY: begin
                char_ready = 1'b1;
                // Ready is unconditionally high in ENTRY, so valid alone
                // means a transfer here.
                if (char_valid && is_term) state_d = COMMIT;
            end
            COMMIT:  state_d = ENTRY;
            default: state_d = ENTRY;
        endcase
    end

    // ---------------- staging buffer and display register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the staging array is a handful of flops, not a RAM, and
            // must power up blank, so it is reset like any other register.
            for (int k = 0; k < NUM_DIGITS; k++) stage_q[k] <= SEG_BLANK;
            disp_q   <= '0;
            count_q  <= 4'd0;
            ovf_q    <= 1'b0;
            commit_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            bad_q    <= 1'b0;
            if (state_q == COMMIT) begin
                // Staging is cleared so an empty line commits a blank display.
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    disp_q[8*k +: 8] <= stage_q[k];
                    stage_q[k]       <= SEG_BLANK;
                end
                count_q  <= 4'd0;
                ovf_q    <= 1'b0;
                commit_q <= 1'b1;
            end else if (xfer && !is_term) begin
                if (dec_valid) begin
                    for (int k = NUM_DIGITS - 1; k > 0; k--) stage_q[k] <= stage_q[k-1];
                    stage_q[0] <= dec_code;
                    if (count_q == FULL_COUNT) ovf_q   <= 1'b1;
                    else                       count_q <= count_q + 4'd1;
                end else if (char_in == DOT) begin
                    stage_q[0][SEG_DP_BIT] <= 1'b1;
                end else if (char_in == BS) begin
                    for (int k = 0; k < NUM_DIGITS - 1; k++) stage_q[k] <= stage_q[k+1];
                    stage_q[NUM_DIGITS-1] <= SEG_BLANK;
                    if (count_q != 4'd0) count_q <= count_q - 4'd1;
                end else begin
                    bad_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- blink timebase and output register ----------------
    // Free-running: enabling blink does not restart the phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_q <= POL_MASK;
        end else if (blank_en || (blink_en && blink_phase_q)) begin
            seg_q <= POL_MASK;
        end else begin
            seg_q <= disp_q ^ POL_MASK;
        end
    end

    assign seg_out      = seg_q;
    assign commit_pulse = commit_q;
    assign bad_char     = bad_q;
    assign overflow     = ovf_q;
    assign char_count   = count_q;

endmodule

// File: tb/tb_seg_ascii_display.sv
// Self-checking bench for seg_ascii_display (4 digits, active-low, BLINK_DIV=4).
// A queue-based reference model tracks what the display must show; a compare
// process checks every output on every falling edge, and directed sequences
// pin the model with hand-computed literal values.
module tb_seg_ascii_display;

    localparam int N    = 4;
    localparam int BDIV = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        blank_en = 1'b0;
    logic        blink_en = 1'b0;
    logic        char_ready;
    logic [31:0] seg_out;
    logic        commit_pulse, bad_char, overflow;
    logic [3:0]  char_count;

    always #5 CLK = ~CLK;

    seg_ascii_display #(
        .NUM_DIGITS (N),
        .ACTIVE_LOW (1),
        .BLINK_DIV  (BDIV)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .blank_en     (blank_en),
        .blink_en     (blink_en),
        .seg_out      (seg_out),
        .commit_pulse (commit_pulse),
        .bad_char     (bad_char),
        .overflow     (overflow),
        .char_count   (char_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [7:0]  m_stage [$];
    logic [7:0]  m_disp [N];
    int          m_count;
    int          m_edges;
    bit          m_ovf, m_commit_p, m_bad, m_in_commit, m_started, m_phase;
    logic [31:0] m_seg;
    int          m_code;

    // Segment code for a digit-position character, or -1.
    function automatic int code_of(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(hex_tab[c - 8'h30]);
        if (c >= "A" && c <= "F") return int'(hex_tab[c - 8'h41 + 10]);
        if (c >= "a" && c <= "f") return int'(hex_tab[c - 8'h61 + 10]);
        if (c == "-") return 32'h40;
        if (c == " ") return 0;
        return -1;
    endfunction

    function automatic logic [31:0] disp_word();
        logic [31:0] w;
        for (int k = 0; k < N; k++) w[8*k +: 8] = m_disp[k];
        return w;
    endfunction

    task automatic model_clear_stage();
        m_stage.delete();
        for (int k = 0; k < N; k++) m_stage.push_back(8'h00);
    endtask

    always @(posedge CLK) begin
        m_started = 1'b1;
        if (RST) begin
            model_clear_stage();
            for (int k = 0; k < N; k++) m_disp[k] = 8'h00;
            m_count = 0; m_edges = 0;
            m_ovf = 0; m_commit_p = 0; m_bad = 0; m_in_commit = 0;
            m_seg = 32'hFFFF_FFFF;
        end else begin
            // Blink phase after m_edges edges since reset.
            m_phase = ((m_edges / BDIV) % 2) == 1;
            m_seg   = ~((blank_en || (blink_en && m_phase)) ? 32'h0 : disp_word());
            m_edges++;
            m_commit_p = 0;
            m_bad      = 0;
            if (m_in_commit) begin
                for (int k = 0; k < N; k++) m_disp[k] = m_stage[k];
                model_clear_stage();
                m_count = 0; m_ovf = 0; m_commit_p = 1; m_in_commit = 0;
            end else if (char_valid) begin
                m_code = code_of(char_in);
                if (char_in == 8'h0D || char_in == 8'h0A) begin
                    m_in_commit = 1;
                end else if (m_code >= 0) begin
                    m_stage.push_front(m_code[7:0]);
                    void'(m_stage.pop_back());
                    if (m_count == N) m_ovf = 1;
                    else              m_count++;
                end else if (char_in == 8'h2E) begin
                    m_stage[0] = m_stage[0] | 8'h80;
                end else if (char_in == 8'h08) begin
                    void'(m_stage.pop_front());
                    m_stage.push_back(8'h00);
                    if (m_count > 0) m_count--;
                end else begin
                    m_bad = 1;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge CLK) begin
        if (m_started) begin
            check("seg_out",      seg_out,      m_seg);
            check("char_ready",   char_ready,   !m_in_commit);
            check("commit_pulse", commit_pulse, m_commit_p);
            check("bad_char",     bad_char,     m_bad);
            check("overflow",     overflow,     m_ovf);
            check("char_count",   char_count,   m_count);
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic send(input logic [7:0] c);
        int budget = 0;
        char_in    = c;
        char_valid = 1'b1;
        while (!char_ready && budget < 20) begin
            @(negedge CLK);
            budget++;
        end
        if (budget >= 20) check("send_timeout", 32'd0, 32'd1);
        @(negedge CLK);
    endtask

    task automatic idle();
        char_valid = 1'b0;
        @(negedge CLK);
    endtask

    string hexs = "0123456789ABCDEFabcdef";
    int    off_cnt;
    bit    rdy_at_set;
    int    r;

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_seg",   seg_out,    32'hFFFF_FFFF);
        check("reset_ready", char_ready, 32'd1);
        check("reset_count", char_count, 32'd0);
        RST = 1'b0;

        // "1234" CR
        send("1"); send("2"); send("3"); send("4"); send(8'h0D);
        check("ready_gap", char_ready, 32'd0);
        idle();
        check("commit_seen", commit_pulse, 32'd1);
        idle();
        check("disp_1234", seg_out, 32'hF9A4_B099);

        // "a-7." LF
        send("a"); send("-"); send("7"); send(".");
        check("count_a-7.", char_count, 32'd3);
        send(8'h0A);
        idle();
        check("count_after_commit", char_count, 32'd0);
        idle();
        check("disp_a-7.", seg_out, 32'hFF88_BF78);

        // "123456" CR: overflow
        send("1"); send("2"); send("3"); send("4");
        check("no_ovf_at_4", overflow, 32'd0);
        send("5");
        check("ovf_at_5", overflow, 32'd1);
        send("6"); send(8'h0D);
        idle();
        check("ovf_cleared", overflow, 32'd0);
        idle();
        check("disp_3456", seg_out, 32'hB099_9282);

        // "12" BS "9" "G" CR
        send("1"); send("2"); send(8'h08); send("9"); send("G");
        check("bad_char_pulse", bad_char, 32'd1);
        idle();
        check("bad_char_once", bad_char, 32'd0);
        send(8'h0D);
        idle(); idle();
        check("disp_bs", seg_out, 32'hFFFF_F990);

        // Reset during COMMIT: no commit, display forced off
        send("8"); send(8'h0D);
        RST = 1'b1;
        idle();
        check("rst_commit_seg",   seg_out,      32'hFFFF_FFFF);
        check("rst_commit_pulse", commit_pulse, 32'd0);
        RST = 1'b0;

        // Back-to-back terminators with valid held
        send("1"); send("2"); send(8'h0D);
        check("cr1_gap", char_ready, 32'd0);
        send(8'h0D);
        check("cr2_gap", char_ready, 32'd0);
        idle(); idle();
        check("empty_commit", seg_out, 32'hFFFF_FFFF);

        // Blink: 16 consecutive cycles must contain exactly 8 off cycles
        send("1"); send("2"); send(8'h0D);
        idle(); idle();
        blink_en = 1'b1;
        idle(); idle();
        off_cnt = 0;
        repeat (16) begin
            if (seg_out == 32'hFFFF_FFFF) off_cnt++;
            idle();
        end
        check("blink_off_cycles", off_cnt, 32'd8);
        blank_en = 1'b1;
        idle();
        check("blank_off", seg_out, 32'hFFFF_FFFF);
        blank_en = 1'b0;
        blink_en = 1'b0;
        idle();

        // Randomised traffic; a held character is kept until it transfers.
        rdy_at_set = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if (!(char_valid && !rdy_at_set)) begin
                char_valid = ($urandom_range(0, 9) < 7);
                r = $urandom_range(0, 99);
                if      (r < 40) char_in = hexs[$urandom_range(0, 21)];
                else if (r < 50) char_in = ($urandom_range(0, 1) != 0) ? "-" : " ";
                else if (r < 58) char_in = ".";
                else if (r < 68) char_in = 8'h08;
                else if (r < 76) char_in = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
                else             char_in = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 19) == 0)  blank_en = ~blank_en;
            if ($urandom_range(0, 9) == 0)   blink_en = ~blink_en;
            RST = ($urandom_range(0, 499) == 0);
            rdy_at_set = char_ready;
            @(negedge CLK);
        end
        RST = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
